// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard: default
// geometry, the hard-wired zero register address, and a popcount helper used
// when checking that pendingCount tracks busyMask.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ADDR_W_DEF    = 5;
  localparam int unsigned ZERO_REG_ADDR = 0;

  // Number of set bits in a vector of up to 64 bits.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_ctl.sv
// Busy scoreboard: tracks which registers have an outstanding writer, raises
// stall on RAW/WAW hazards, and keeps a running count of busy registers.
module regfile_scoreboard_ctl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          rs,
  input  logic [ADDR_W-1:0]          rt,
  input  logic                       regWrite,
  input  logic [ADDR_W-1:0]          writeReg,
  input  logic                       issueValid,
  input  logic                       useRs,
  input  logic                       useRt,
  input  logic                       issueDst,
  input  logic [ADDR_W-1:0]          issueReg,
  output logic                       stall,
  output logic [(2**ADDR_W)-1:0]     busyMask,
  output logic [ADDR_W:0]            pendingCount
);

  localparam int unsigned       DEPTH     = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  count;
  logic [ADDR_W:0]  count_next;
  logic             hz_rs;
  logic             hz_rt;
  logic             hz_dst;
  logic             stall_int;
  logic             set_new;
  logic             clr_old;

  // Register 0 is read-only when the zero register is enabled.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG && (a == ZERO_ADDR));
  endfunction

  // A busy register stops being a hazard in the cycle its writeback is
  // forwarded, so the consumer can issue alongside the producer's write.
  function automatic logic busy_eff(input logic [DEPTH-1:0]  b,
                                    input logic [ADDR_W-1:0] a,
                                    input logic              wr,
                                    input logic [ADDR_W-1:0] wa);
    return b[a] & ~(BYPASS & wr & (wa == a));
  endfunction

  // Hazard detection: RAW on either source, WAW on the destination.
  always_comb begin
    hz_rs     = useRs    & busy_eff(busy, rs, regWrite, writeReg);
    hz_rt     = useRt    & busy_eff(busy, rt, regWrite, writeReg);
    hz_dst    = issueDst & busy_eff(busy, issueReg, regWrite, writeReg);
    stall_int = issueValid & (hz_rs | hz_rt | hz_dst);
  end

  // Next busy state and count; a claim and a release on the same register
  // in one cycle leave the bit set and the count unchanged.
  always_comb begin
    set_new   = issueValid & ~stall_int & issueDst & writable(issueReg);
    clr_old   = regWrite & busy[writeReg];
    busy_next = busy;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (set_new && (issueReg == ADDR_W'(i))) begin
        busy_next[i] = 1'b1;
      end else if (regWrite && (writeReg == ADDR_W'(i))) begin
        busy_next[i] = 1'b0;
      end else begin
        busy_next[i] = busy[i];
      end
    end
    count_next = count + (ADDR_W + 1)'(set_new) - (ADDR_W + 1)'(clr_old);
  end

  // Scoreboard state register; reset discards every outstanding claim.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= busy_next;
      count <= count_next;
    end
  end

  assign stall        = stall_int;
  assign busyMask     = busy;
  assign pendingCount = count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one synchronous write
// port, optional hard-wired zero register, optional write-to-read bypass,
// and a busy scoreboard for decode-stage hazard stalls.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      rs,
  input  logic [ADDR_W-1:0]      rt,
  output logic [DATA_W-1:0]      readReg_1,
  output logic [DATA_W-1:0]      readReg_2,
  input  logic                   regWrite,
  input  logic [ADDR_W-1:0]      writeReg,
  input  logic [DATA_W-1:0]      writeData,
  input  logic                   issueValid,
  input  logic                   useRs,
  input  logic                   useRt,
  input  logic                   issueDst,
  input  logic [ADDR_W-1:0]      issueReg,
  output logic                   stall,
  output logic [(2**ADDR_W)-1:0] busyMask,
  output logic [ADDR_W:0]        pendingCount
);

  localparam int unsigned       DEPTH     = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);

  logic [DATA_W-1:0] regs [DEPTH];

  // Register 0 is read-only when the zero register is enabled.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !(ZERO_REG && (a == ZERO_ADDR));
  endfunction

  // Storage array; reset clears every entry so nothing survives a flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (regWrite && writable(writeReg)) begin
      regs[writeReg] <= writeData;
    end else begin
      regs <= regs;
    end
  end

  // Read port 1: zero register, then bypassed writeback, then storage.
  always_comb begin
    if (ZERO_REG && (rs == ZERO_ADDR)) begin
      readReg_1 = '0;
    end else if (BYPASS && regWrite && (writeReg == rs)) begin
      readReg_1 = writeData;
    end else begin
      readReg_1 = regs[rs];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    if (ZERO_REG && (rt == ZERO_ADDR)) begin
      readReg_2 = '0;
    end else if (BYPASS && regWrite && (writeReg == rt)) begin
      readReg_2 = writeData;
    end else begin
      readReg_2 = regs[rt];
    end
  end

  regfile_scoreboard_ctl #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_ctl (
    .clk          (clk),
    .rst          (rst),
    .rs           (rs),
    .rt           (rt),
    .regWrite     (regWrite),
    .writeReg     (writeReg),
    .issueValid   (issueValid),
    .useRs        (useRs),
    .useRt        (useRt),
    .issueDst     (issueDst),
    .issueReg     (issueReg),
    .stall        (stall),
    .busyMask     (busyMask),
    .pendingCount (pendingCount)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one instance with bypass and one
// without, sharing stimulus; expected values are written out by hand.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        issueValid;
  logic        useRs;
  logic        useRt;
  logic        issueDst;
  logic [4:0]  issueReg;

  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        stall, nb_stall;
  logic [31:0] busy_mask, nb_busy_mask;
  logic [5:0]  pending, nb_pending;

  int vectors = 0;
  int errors  = 0;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .readReg_1(rd1), .readReg_2(rd2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .issueValid(issueValid), .useRs(useRs), .useRt(useRt),
    .issueDst(issueDst), .issueReg(issueReg),
    .stall(stall), .busyMask(busy_mask), .pendingCount(pending)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt),
    .readReg_1(nb_rd1), .readReg_2(nb_rd2),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .issueValid(issueValid), .useRs(useRs), .useRt(useRt),
    .issueDst(issueDst), .issueReg(issueReg),
    .stall(nb_stall), .busyMask(nb_busy_mask), .pendingCount(nb_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite   = 1'b0;
    writeReg   = 5'd0;
    writeData  = 32'd0;
    issueValid = 1'b0;
    useRs      = 1'b0;
    useRt      = 1'b0;
    issueDst   = 1'b0;
    issueReg   = 5'd0;
  endtask

  task automatic chk_pop(input string tag);
    chk(tag, 64'(pending), 64'(popcount({32'd0, busy_mask})));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rs  = 5'd0;
    rt  = 5'd0;
    idle();

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_rd1", 64'(rd1), 64'h0);
    chk("rst_busy", 64'(busy_mask), 64'h0);
    chk("rst_cnt", 64'(pending), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    tick();
    tick();
    rst = 1'b1;

    // Zero register ignores writes and never forwards
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hDEADBEEF; rs = 5'd0;
    #1;
    chk("zero_byp", 64'(rd1), 64'h0);
    tick();
    idle();
    #1;
    chk("zero_rd", 64'(rd1), 64'h0);
    chk("zero_busy", 64'(busy_mask), 64'h0);
    chk("zero_cnt", 64'(pending), 64'h0);

    // Bypass vs. no bypass
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h0000_1234; rs = 5'd5; rt = 5'd5;
    #1;
    chk("byp_rd1", 64'(rd1), 64'h1234);
    chk("byp_rd2", 64'(rd2), 64'h1234);
    chk("nobyp_rd1_old", 64'(nb_rd1), 64'h0);
    tick();
    idle();
    #1;
    chk("byp_rd2_next", 64'(rd2), 64'h1234);
    chk("nobyp_rd1_next", 64'(nb_rd1), 64'h1234);

    // RAW stall
    issueValid = 1'b1; issueDst = 1'b1; issueReg = 5'd7;
    #1;
    chk("raw_issue_stall", 64'(stall), 64'h0);
    tick();
    idle();
    issueValid = 1'b1; useRs = 1'b1; rs = 5'd7;
    #1;
    chk("raw_busy", 64'(busy_mask), 64'h80);
    chk("raw_cnt", 64'(pending), 64'h1);
    chk("raw_stall", 64'(stall), 64'h1);
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'h77;
    #1;
    chk("raw_wb_stall", 64'(stall), 64'h0);
    chk("raw_wb_rd1", 64'(rd1), 64'h77);
    chk("raw_nobyp_stall", 64'(nb_stall), 64'h1);
    tick();
    idle();
    #1;
    chk("raw_clr_busy", 64'(busy_mask), 64'h0);
    chk("raw_clr_cnt", 64'(pending), 64'h0);
    chk("raw_nobyp_cnt", 64'(nb_pending), 64'h0);

    // WAW and set-wins; source not checked when useRs=0
    issueValid = 1'b1; issueDst = 1'b1; issueReg = 5'd9;
    tick();
    issueReg = 5'd10; rs = 5'd9; useRs = 1'b0;
    #1;
    chk("nouse_stall", 64'(stall), 64'h0);
    tick();
    issueReg = 5'd9;
    #1;
    chk("waw_cnt", 64'(pending), 64'h2);
    chk("waw_stall", 64'(stall), 64'h1);
    regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h99;
    #1;
    chk("waw_wb_stall", 64'(stall), 64'h0);
    tick();
    idle();
    #1;
    chk("setwins_busy", 64'(busy_mask), 64'h600);
    chk("setwins_cnt", 64'(pending), 64'h2);
    regWrite = 1'b1; writeReg = 5'd12; writeData = 32'hC;
    tick();
    chk("nonbusy_wr_cnt", 64'(pending), 64'h2);
    writeReg = 5'd9;
    tick();
    writeReg = 5'd10;
    tick();
    idle();
    chk("waw_drain_cnt", 64'(pending), 64'h0);
    chk("waw_drain_busy", 64'(busy_mask), 64'h0);

    // Claims that set nothing
    issueValid = 1'b1; issueDst = 1'b1; issueReg = 5'd0;
    tick();
    chk("issue_r0_cnt", 64'(pending), 64'h0);
    issueDst = 1'b0; issueReg = 5'd3;
    tick();
    chk("issue_nodst_cnt", 64'(pending), 64'h0);

    // Fill 1..31
    for (int i = 1; i < 32; i++) begin
      issueValid = 1'b1; issueDst = 1'b1; issueReg = 5'(i);
      #1;
      chk("fill_stall", 64'(stall), 64'h0);
      tick();
      chk("fill_cnt", 64'(pending), 64'(i));
      chk_pop("fill_pop");
    end
    issueReg = 5'd5;
    #1;
    chk("full_waw_stall", 64'(stall), 64'h1);
    tick();
    chk("full_cnt", 64'(pending), 64'd31);
    chk("full_busy", 64'(busy_mask), 64'hFFFF_FFFE);

    // Drain 31..1
    idle();
    for (int i = 31; i >= 1; i--) begin
      regWrite = 1'b1; writeReg = 5'(i); writeData = 32'(i);
      tick();
      chk("drain_cnt", 64'(pending), 64'(i - 1));
      chk_pop("drain_pop");
    end
    idle();

    // Asynchronous reset mid-operation
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5A5A5A5;
    tick();
    idle();
    for (int i = 1; i <= 4; i++) begin
      issueValid = 1'b1; issueDst = 1'b1; issueReg = 5'(i);
      tick();
    end
    idle();
    rs = 5'd3;
    #1;
    chk("pre_rst_rd1", 64'(rd1), 64'hA5A5A5A5);
    chk("pre_rst_cnt", 64'(pending), 64'h4);
    chk("pre_rst_busy", 64'(busy_mask), 64'h1E);
    rst = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy_mask), 64'h0);
    chk("async_rst_cnt", 64'(pending), 64'h0);
    chk("async_rst_rd1", 64'(rd1), 64'h0);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_rd1", 64'(rd1), 64'h0);
    chk("post_rst_cnt", 64'(pending), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
